uart_rx_param: RTL

Parametrised oversampling UART receiver, the successor to the team's fixed 8-data-bit, even-parity receiver. It deserialises one asynchronous serial line into parallel words with configurable data width, parity mode, stop-bit count and bit period. It adds input synchronisation, 3-sample majority voting, false-start rejection and break detection. It sits between the board RX pin and the byte-consuming logic (loopback or command parser), all in the `clk` domain.

---
 rtl/uart_rx_param.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with input synchroniser, 3-sample
// majority voting, false-start rejection, frame/parity error and break detection.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dataout,
    output logic                 rdsig,
    output logic                 dataerror,
    output logic                 frameerror,
    output logic                 breakdet,
    output logic                 busy
);
    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int MID = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] C_ONE     = CW'(1);
    localparam logic [CW-1:0] C_S0      = CW'(MID - 1);
    localparam logic [CW-1:0] C_S1      = CW'(MID);
    localparam logic [CW-1:0] C_VOTE    = CW'(MID + 1);
    localparam logic [CW-1:0] C_LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] C_LASTBIT = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] C_BITONE  = BW'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_rxPrev;
    logic [CW-1:0]         r_cnt;
    logic                  r_s0;
    logic                  r_s1;
    logic [DATA_BITS-1:0]  r_shift;
    logic [BW-1:0]         r_bitIdx;
    logic                  r_stopIdx;
    logic                  r_parBit;
    logic                  r_frameErr;

    logic w_rxS;
    logic w_fall;
    logic w_atVote;
    logic w_atEnd;
    logic w_vote;
    logic w_lastData;
    logic w_lastStop;
    logic w_done;
    logic w_frameErrNow;
    logic w_parExp;

    assign w_rxS         = r_sync2;
    assign w_fall        = r_rxPrev & ~w_rxS;
    assign w_atVote      = (r_cnt == C_VOTE);
    assign w_atEnd       = (r_cnt == C_LAST);
    assign w_vote        = (r_s0 & r_s1) | (r_s0 & w_rxS) | (r_s1 & w_rxS);
    assign w_lastData    = (r_bitIdx == C_LASTBIT);
    assign w_lastStop    = (STOP_BITS == 1) ? 1'b1 : r_stopIdx;
    assign w_done        = (r_state == S_STOP) && w_atVote && w_lastStop;
    assign w_frameErrNow = r_frameErr | ~w_vote;
    assign w_parExp      = (PARITY == 2) ? ~(^r_shift) : ^r_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_fall) w_next = S_START;
            S_START: begin
                if (w_atVote && w_vote) w_next = S_IDLE;
                else if (w_atEnd)       w_next = S_DATA;
            end
            S_DATA: begin
                if (w_atEnd && w_lastData) w_next = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY:    if (w_atEnd) w_next = S_STOP;
            S_STOP:      if (w_done) w_next = w_frameErrNow ? S_WAIT_HIGH : S_IDLE;
            S_WAIT_HIGH: if (w_rxS) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
    end

    // The edge-detect cycle itself is count 0 of the start bit, so START begins at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rxPrev   <= 1'b1;
            r_cnt      <= '0;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_shift    <= '0;
            r_bitIdx   <= '0;
            r_stopIdx  <= 1'b0;
            r_parBit   <= 1'b0;
            r_frameErr <= 1'b0;
            dataout    <= '0;
            rdsig      <= 1'b0;
            dataerror  <= 1'b0;
            frameerror <= 1'b0;
            breakdet   <= 1'b0;
        end else begin
            r_sync1  <= rx;
            r_sync2  <= r_sync1;
            r_rxPrev <= w_rxS;
            rdsig    <= 1'b0;

            if (r_state == S_IDLE) begin
                r_cnt <= w_fall ? C_ONE : '0;
            end else if (r_state == S_WAIT_HIGH || w_next == S_IDLE || w_next == S_WAIT_HIGH) begin
                r_cnt <= '0;
            end else if (w_atEnd) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + C_ONE;
            end

            if (r_cnt == C_S0) r_s0 <= w_rxS;
            if (r_cnt == C_S1) r_s1 <= w_rxS;

            if (r_state == S_IDLE) begin
                r_bitIdx   <= '0;
                r_stopIdx  <= 1'b0;
                r_frameErr <= 1'b0;
            end

            if (r_state == S_DATA) begin
                if (w_atVote) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                if (w_atEnd && !w_lastData) r_bitIdx <= r_bitIdx + C_BITONE;
            end

            if (r_state == S_PARITY && w_atVote) r_parBit <= w_vote;

            if (r_state == S_STOP && w_atVote) begin
                if (!w_lastStop) begin
                    r_frameErr <= w_frameErrNow;
                    r_stopIdx  <= 1'b1;
                end else begin
                    dataout    <= r_shift;
                    rdsig      <= 1'b1;
                    frameerror <= w_frameErrNow;
                    dataerror  <= (PARITY != 0) && (r_parBit != w_parExp);
                    breakdet   <= w_frameErrNow && (r_shift == '0) && ((PARITY == 0) || !r_parBit);
                end
            end
        end
    end
endmodule
